// File: rtl/grapheme_pxl_mem_pkg.sv
// Shared types and constants for the pixel-memory arbiter slice.
package grapheme_pxl_mem_pkg;

    // Current owner of the pixel-memory port.
    typedef enum logic [1:0] {
        NONE = 2'd0,
        DISP = 2'd1,
        GW   = 2'd2
    } pxl_mem_owner_t;

    // Tag stored per outstanding read, selects the read-return destination.
    localparam logic PXL_MEM_TAG_DISP = 1'b0;
    localparam logic PXL_MEM_TAG_GW   = 1'b1;

    // Bit positions inside the status word.
    localparam int ST_RD_UNDRFLW  = 0;
    localparam int ST_ILLEGAL_REQ = 1;
    localparam int ST_TAG_FULL    = 2;
    localparam int ST_STARVE_MAX  = 3;
    localparam int ST_LOCK_LSB    = 4;
    localparam int ST_USED_LSB    = 6;

endpackage

// File: rtl/grapheme_pxl_mem_tag_ff.sv
// First-word-fall-through FIFO of 1-bit read tags. A pop and a push in the
// same cycle are allowed even when full: the freed head slot takes the push.
module grapheme_pxl_mem_tag_ff #(
    parameter int TAG_FF_D = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic                        push_tag,
    input  logic                        pop,
    output logic                        head,
    output logic                        full,
    output logic                        empty,
    output logic [$clog2(TAG_FF_D):0]   used
);

    localparam int AW = $clog2(TAG_FF_D);
    localparam int UW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [UW-1:0] USED_ONE = UW'(1);
    localparam logic [UW-1:0] USED_MAX = UW'(TAG_FF_D);

    logic          tag_mem [TAG_FF_D];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          pop_eff;
    logic          push_eff;

    assign empty    = (used == '0);
    assign full     = (used == USED_MAX);
    assign pop_eff  = pop & ~empty;
    assign push_eff = push & (~full | pop_eff);
    assign head     = tag_mem[rd_ptr];

    // Tag storage; contents are only meaningful while counted in used.
    always_ff @(posedge clk) begin
        if (push_eff) begin
            tag_mem[wr_ptr] <= push_tag;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            used   <= '0;
        end else begin
            if (push_eff) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_eff) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_eff, pop_eff})
                2'b10:   used <= used + USED_ONE;
                2'b01:   used <= used - USED_ONE;
                default: used <= used;
            endcase
        end
    end

endmodule

// File: rtl/grapheme_pxl_mem_arb.sv
// Arbiter for the single pixel-memory port shared by the display fetcher
// (read-only, high priority) and the pixel gateway (read/write). Issues pass
// straight through; read data is steered back in order via a tag FIFO.
module grapheme_pxl_mem_arb
    import grapheme_pxl_mem_pkg::*;
#(
    parameter int MEM_DATA_W  = 32,
    parameter int MEM_ADDR_W  = 20,
    parameter int TAG_FF_D    = 16,
    parameter int GW_MAX_WAIT = 8,
    parameter int STATUS_W    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  disp_rden,
    input  logic [MEM_ADDR_W-1:0] disp_addr,
    output logic                  disp_wait,
    output logic                  disp_rd_valid,
    output logic [MEM_DATA_W-1:0] disp_rdata,
    input  logic                  gw_wren,
    input  logic                  gw_rden,
    input  logic [MEM_ADDR_W-1:0] gw_addr,
    input  logic [MEM_DATA_W-1:0] gw_wdata,
    output logic                  gw_wait,
    output logic                  gw_rd_valid,
    output logic [MEM_DATA_W-1:0] gw_rdata,
    output logic                  mem_wren,
    output logic                  mem_rden,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [MEM_DATA_W-1:0] mem_wdata,
    input  logic                  mem_wait,
    input  logic                  mem_rd_valid,
    input  logic [MEM_DATA_W-1:0] mem_rdata,
    input  logic                  clear_flags,
    output logic [STATUS_W-1:0]   status
);

    localparam int TAG_UW = $clog2(TAG_FF_D) + 1;
    localparam int SW     = $clog2(GW_MAX_WAIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(GW_MAX_WAIT);
    localparam logic [SW-1:0] STARVE_ONE = SW'(1);

    pxl_mem_owner_t    lock;
    pxl_mem_owner_t    lock_nxt;
    pxl_mem_owner_t    grant;
    logic [SW-1:0]     starve_cnt;
    logic [SW-1:0]     starve_nxt;
    logic              starve_max;
    logic              gw_req;
    logic              gw_is_rd;
    logic              ff_blk;
    logic              disp_acc;
    logic              gw_acc;
    logic              issue;
    logic              tag_push;
    logic              tag_push_val;
    logic              tag_head;
    logic              tag_full;
    logic              tag_empty;
    logic [TAG_UW-1:0] tag_used;
    logic              ret_hit;
    logic              rd_undrflw;
    logic              illegal_req;

    // A simultaneous write and read from the gateway is treated as a write.
    assign gw_req     = gw_wren | gw_rden;
    assign gw_is_rd   = gw_rden & ~gw_wren;
    assign starve_max = (starve_cnt == STARVE_MAX);
    // A return arriving this cycle frees a tag slot, so a full FIFO only blocks
    // reads when nothing is being popped.
    assign ff_blk     = tag_full & ~mem_rd_valid;

    // Grant: held owner first, then starved gateway, then display, then gateway.
    always_comb begin
        grant = NONE;
        if (lock != NONE) begin
            grant = lock;
        end else if (gw_req && starve_max) begin
            grant = GW;
        end else if (disp_rden) begin
            grant = DISP;
        end else if (gw_req) begin
            grant = GW;
        end
    end

    // Steer the grantee onto the memory port and produce both wait signals.
    always_comb begin
        mem_wren  = 1'b0;
        mem_rden  = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        disp_wait = 1'b1;
        gw_wait   = 1'b1;
        case (grant)
            DISP: begin
                mem_rden  = disp_rden & ~ff_blk;
                mem_addr  = disp_addr;
                disp_wait = mem_wait | ff_blk;
            end
            GW: begin
                mem_wren  = gw_wren;
                mem_rden  = gw_is_rd & ~ff_blk;
                mem_addr  = gw_addr;
                mem_wdata = gw_wdata;
                gw_wait   = mem_wait | (gw_is_rd & ff_blk);
            end
            default: ;
        endcase
    end

    assign disp_acc     = disp_rden & ~disp_wait;
    assign gw_acc       = gw_req & ~gw_wait;
    assign issue        = mem_rden | mem_wren;
    assign tag_push     = mem_rden & ~mem_wait;
    assign tag_push_val = (grant == GW) ? PXL_MEM_TAG_GW : PXL_MEM_TAG_DISP;

    // Next lock owner and starvation count.
    always_comb begin
        lock_nxt   = lock;
        starve_nxt = '0;
        if (disp_acc || gw_acc) begin
            lock_nxt = NONE;
        end else if (issue && mem_wait) begin
            lock_nxt = grant;
        end
        if (gw_req && !gw_acc) begin
            starve_nxt = starve_max ? starve_cnt : starve_cnt + STARVE_ONE;
        end
    end

    // Lock and starvation registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock       <= NONE;
            starve_cnt <= '0;
        end else begin
            lock       <= lock_nxt;
            starve_cnt <= starve_nxt;
        end
    end

    grapheme_pxl_mem_tag_ff #(
        .TAG_FF_D (TAG_FF_D)
    ) u_tag_ff (
        .clk      (clk),
        .rst      (rst),
        .push     (tag_push),
        .push_tag (tag_push_val),
        .pop      (mem_rd_valid),
        .head     (tag_head),
        .full     (tag_full),
        .empty    (tag_empty),
        .used     (tag_used)
    );

    // Route returning read data to the owner of the oldest outstanding read.
    always_comb begin
        ret_hit       = mem_rd_valid & ~tag_empty;
        disp_rd_valid = ret_hit & (tag_head == PXL_MEM_TAG_DISP);
        gw_rd_valid   = ret_hit & (tag_head == PXL_MEM_TAG_GW);
        disp_rdata    = disp_rd_valid ? mem_rdata : '0;
        gw_rdata      = gw_rd_valid ? mem_rdata : '0;
    end

    // Sticky error flags; a new event in the clearing cycle keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_undrflw  <= 1'b0;
            illegal_req <= 1'b0;
        end else begin
            rd_undrflw  <= (mem_rd_valid & tag_empty) | (rd_undrflw & ~clear_flags);
            illegal_req <= (gw_wren & gw_rden) | (illegal_req & ~clear_flags);
        end
    end

    // Pack the status word.
    always_comb begin
        status                            = '0;
        status[ST_RD_UNDRFLW]             = rd_undrflw;
        status[ST_ILLEGAL_REQ]            = illegal_req;
        status[ST_TAG_FULL]               = tag_full;
        status[ST_STARVE_MAX]             = starve_max;
        status[ST_LOCK_LSB +: 2]          = lock;
        status[ST_USED_LSB +: TAG_UW]     = tag_used;
    end

endmodule

// File: doc/grapheme_pxl_mem_arb.md
Name: grapheme_pxl_mem_arb

Overview:
- Arbitrates the single pixel-memory port (1280x720 frame store, word-addressed, wait/valid handshake) between two requesters: the display refresh fetcher (DISP, read-only, high priority) and the pixel gateway (GW, read/write).
- Issues are passed through with zero latency to the memory port.
- Read data is routed back in order using a tag FIFO of outstanding reads.
- Includes a starvation guard so GW is never locked out by continuous display traffic.

Parameters:
- MEM_DATA_W, 32, memory data width
- MEM_ADDR_W, 20, memory address width
- TAG_FF_D, 16, max outstanding reads (power of 2)
- GW_MAX_WAIT, 8, cycles GW may be held off before it gets priority
- STATUS_W, 32, status width

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- disp_rden  in  1  display read request
- disp_addr  in  MEM_ADDR_W  display address
- disp_wait  out  1  display request not accepted this cycle
- disp_rd_valid  out  1  display read data valid
- disp_rdata  out  MEM_DATA_W  display read data
- gw_wren  in  1  gateway write request
- gw_rden  in  1  gateway read request
- gw_addr  in  MEM_ADDR_W  gateway address
- gw_wdata  in  MEM_DATA_W  gateway write data
- gw_wait  out  1  gateway request not accepted
- gw_rd_valid  out  1  gateway read data valid
- gw_rdata  out  MEM_DATA_W  gateway read data
- mem_wren  out  1  memory write
- mem_rden  out  1  memory read
- mem_addr  out  MEM_ADDR_W  memory address
- mem_wdata  out  MEM_DATA_W  memory write data
- mem_wait  in  1  memory stall
- mem_rd_valid  in  1  memory read data valid
- mem_rdata  in  MEM_DATA_W  memory read data
- clear_flags  in  1  clears sticky error flags
- status  out  STATUS_W  status word

Behaviour:
- Requester protocol: a request (rden/wren) is held with stable addr/wdata until a cycle where it is asserted and its wait is 0; that cycle is the acceptance. gw_wren and gw_rden are never asserted together; if they are, the write wins and the illegal_req sticky flag is set.
- Grant (combinational), evaluated each cycle:
  - If lock != NONE, grant = lock.
  - Else if the GW request is present and starve_cnt == GW_MAX_WAIT, grant = GW.
  - Else if DISP requests, grant = DISP.
  - Else if GW requests, grant = GW.
  - Else grant = NONE.
- Lock register (states NONE/DISP/GW, reset NONE):
  - Loaded with the grantee when the grantee's request is driven to memory and mem_wait = 1.
  - Returns to NONE on the acceptance cycle.
  - An issue in progress is therefore never pre-empted, and the address is never switched mid-stall.
- Memory outputs:
  - mem_* = the grantee's request/addr/wdata; when grant = NONE, mem_wren = mem_rden = 0 and addr/wdata are 0.
  - mem_rden is additionally forced to 0 when the tag FIFO is full.
- Wait outputs:
  - The grantee's wait = mem_wait, OR (request is a read AND tag FIFO full).
  - A non-grantee's wait = 1.
- Starvation counter starve_cnt (reset 0):
  - Increments, saturating at GW_MAX_WAIT, each cycle GW requests and is not accepted.
  - Clears on GW acceptance or when GW has no request.
- Tag FIFO (1-bit tag: 0 = DISP, 1 = GW), first-word-fall-through:
  - Push on each accepted memory read.
  - Pop on mem_rd_valid.
  - Simultaneous push and pop is legal; occupancy is unchanged.
- Read return: on mem_rd_valid, the head tag selects the destination. That requester's rd_valid = 1 and rdata = mem_rdata, combinationally with zero latency. The other requester's rd_valid = 0.
- Underflow: mem_rd_valid with the tag FIFO empty drops the data and sets the sticky rd_undrflw flag.
- Reset values:
  - All mem_* outputs 0.
  - disp_wait = gw_wait = 1 while no request is present.
  - rd_valid outputs 0.
  - Tag FIFO empty, flags 0.
- Reset mid-operation: lock, counter and FIFO are cleared immediately. Any in-flight read data that arrives after reset is treated as underflow.
- Sticky flags (rd_undrflw, illegal_req) clear on clear_flags. If set and clear occur in the same cycle, set wins.
- status = {zeros, tag_ff_used, lock[1:0], starve_cnt at MAX (1 bit), tag_ff_full, illegal_req, rd_undrflw}, with LSB = rd_undrflw.

Decomposition:
- Shared package grapheme_pxl_mem_pkg holds:
  - owner enum pxl_mem_owner_t {NONE, DISP, GW}
  - tag encodings PXL_MEM_TAG_DISP = 0, PXL_MEM_TAG_GW = 1
  - status bit index constants
- Sub-module grapheme_pxl_mem_tag_ff: synchronous FWFT FIFO, width 1, depth TAG_FF_D, with full/empty/used outputs.

Test Plan:
- DISP reads addr 0x100 and GW writes addr 0x200 with data 0xA5A5A5A5 in the same cycle, mem_wait = 0 → DISP is accepted first; GW is accepted the next cycle with mem_wdata 0xA5A5A5A5.
- GW read at 0x50 with mem_wait high for 3 cycles while DISP raises a request in cycle 2 → mem_addr stays 0x50 until acceptance; DISP is issued on the following cycle.
- DISP requests continuously, GW requests continuously, mem_wait = 0 → GW is granted on exactly the cycle starve_cnt reaches 8, then DISP resumes.
- Interleave DISP read, GW read, DISP read, with rdata returned 3 cycles later as 0x1, 0x2, 0x3 → disp receives 0x1 and 0x3, gw receives 0x2, in order.
- Issue 16 reads with no mem_rd_valid returned → 17th read sees wait = 1 and mem_rden = 0; one mem_rd_valid pop lets the read be accepted in the same cycle.
- mem_rd_valid with empty FIFO → status[0] = 1, no rd_valid to either requester; clear_flags → status[0] = 0.
